// File: rtl/text_scene_ctrl.sv
// Scene sequencer (TITLE/HOWTO/PLAY/OVER) with frame-aligned commits and a 1-clock registered text colour resolver.
// Optional macro TEXT_BLINK_EN: selected menu item blinks; otherwise it is steady yellow.
module text_scene_ctrl #(
  parameter int BLINK_FRAMES = 15,
  parameter int HOWTO_FRAMES = 600,
  parameter int OVER_FRAMES  = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_select,
  input  logic        btn_confirm,
  input  logic        game_over,
  input  logic        start_text_on,
  input  logic        howto_title_on,
  input  logic        score_text_on,
  input  logic        hp_text_on,
  input  logic        instr_line1_on,
  input  logic        instr_line2_on,
  input  logic        instr_line3_on,
  input  logic        instr_line4_on,
  input  logic        instr_line5_on,
  input  logic        instr_line6_on,
  input  logic        instr_green_on,
  input  logic        instr_red_on,
  output logic [1:0]  scene,
  output logic        cursor,
  output logic        game_run,
  output logic        text_pixel_on,
  output logic [11:0] text_rgb
);

  localparam logic [1:0] S_TITLE = 2'd0;
  localparam logic [1:0] S_HOWTO = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [9:0] HOWTO_LIM = 10'(HOWTO_FRAMES);
  localparam logic [9:0] OVER_LIM  = 10'(OVER_FRAMES);
  localparam logic [9:0] TIMER_MAX = 10'h3FF;

  localparam logic [11:0] RGB_OFF   = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_GREY  = 12'h888;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_RED   = 12'hF00;

  if (BLINK_FRAMES < 1 || HOWTO_FRAMES > 1023 || OVER_FRAMES > 1023) begin : g_param_err
    $error("text_scene_ctrl: parameter out of range");
  end

  logic [1:0]  scene_q, scene_d;
  logic        cursor_q, cursor_d;
  logic        pend_valid_q, pend_valid_d;
  logic [1:0]  pend_scene_q, pend_scene_d;
  logic [9:0]  timer_q, timer_d;
  logic        sel_dly_q, conf_dly_q;
  logic        pix_on_q, pix_on_d;
  logic [11:0] rgb_q, rgb_d;

  logic sel_edge, conf_edge, commit, timed_scene;

  assign sel_edge    = btn_select & ~sel_dly_q;
  assign conf_edge   = btn_confirm & ~conf_dly_q;
  assign commit      = frame_tick & pend_valid_q;
  assign timed_scene = (scene_q == S_HOWTO) || (scene_q == S_OVER);

  always_comb begin
    scene_d      = scene_q;
    cursor_d     = cursor_q;
    pend_valid_d = pend_valid_q;
    pend_scene_d = pend_scene_q;
    timer_d      = timer_q;
    if (commit) begin
      scene_d      = pend_scene_q;
      pend_valid_d = 1'b0;
      timer_d      = 10'd0;
      if (pend_scene_q == S_TITLE) cursor_d = 1'b0;
    end else begin
      if (!timed_scene) timer_d = 10'd0;
      else if (frame_tick && timer_q != TIMER_MAX) timer_d = timer_q + 10'd1;

      // A pending request locks out every new event until it commits.
      if (!pend_valid_q) begin
        case (scene_q)
          S_TITLE: begin
            if (conf_edge) begin
              pend_valid_d = 1'b1;
              pend_scene_d = cursor_q ? S_HOWTO : S_PLAY;
            end else if (sel_edge) begin
              cursor_d = ~cursor_q;
            end
          end
          S_HOWTO: begin
            if (conf_edge || timer_q >= HOWTO_LIM) begin
              pend_valid_d = 1'b1;
              pend_scene_d = S_TITLE;
            end
          end
          S_PLAY: begin
            if (game_over) begin
              pend_valid_d = 1'b1;
              pend_scene_d = S_OVER;
            end
          end
          default: begin
            if (timer_q >= OVER_LIM) begin
              pend_valid_d = 1'b1;
              pend_scene_d = S_TITLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q      <= S_TITLE;
      cursor_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_scene_q <= S_TITLE;
      timer_q      <= 10'd0;
      sel_dly_q    <= 1'b0;
      conf_dly_q   <= 1'b0;
    end else begin
      scene_q      <= scene_d;
      cursor_q     <= cursor_d;
      pend_valid_q <= pend_valid_d;
      pend_scene_q <= pend_scene_d;
      timer_q      <= timer_d;
      sel_dly_q    <= btn_select;
      conf_dly_q   <= btn_confirm;
    end
  end

  logic        sel_on;
  logic [11:0] sel_rgb;

`ifdef TEXT_BLINK_EN
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
  logic [9:0] blink_cnt_q;
  logic       blink_phase_q;

  always_ff @(posedge clk) begin
    if (rst || commit) begin
      blink_cnt_q   <= 10'd0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= 10'd0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 10'd1;
      end
    end
  end

  assign sel_on  = blink_phase_q;
  assign sel_rgb = blink_phase_q ? RGB_WHITE : RGB_OFF;
`else
  assign sel_on  = 1'b1;
  assign sel_rgb = 12'hFF0;
`endif

  always_comb begin
    pix_on_d = 1'b0;
    rgb_d    = RGB_OFF;
    case (scene_q)
      S_TITLE: begin
        // A blanked selected item still claims the pixel, so the other item never shows through.
        if (start_text_on) begin
          pix_on_d = cursor_q ? 1'b1 : sel_on;
          rgb_d    = cursor_q ? RGB_GREY : sel_rgb;
        end else if (howto_title_on) begin
          pix_on_d = cursor_q ? sel_on : 1'b1;
          rgb_d    = cursor_q ? sel_rgb : RGB_GREY;
        end
      end
      S_HOWTO: begin
        if (instr_green_on) begin
          pix_on_d = 1'b1;
          rgb_d    = RGB_GREEN;
        end else if (instr_red_on) begin
          pix_on_d = 1'b1;
          rgb_d    = RGB_RED;
        end else if (instr_line1_on | instr_line2_on | instr_line3_on |
                     instr_line4_on | instr_line5_on | instr_line6_on) begin
          pix_on_d = 1'b1;
          rgb_d    = RGB_WHITE;
        end
      end
      S_PLAY: begin
        if (score_text_on | hp_text_on) begin
          pix_on_d = 1'b1;
          rgb_d    = RGB_WHITE;
        end
      end
      default: begin
        if (score_text_on | hp_text_on) begin
          pix_on_d = 1'b1;
          rgb_d    = RGB_RED;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_on_q <= 1'b0;
      rgb_q    <= RGB_OFF;
    end else begin
      pix_on_q <= pix_on_d;
      rgb_q    <= rgb_d;
    end
  end

  assign scene         = scene_q;
  assign cursor        = cursor_q;
  assign game_run      = (scene_q == S_PLAY);
  assign text_pixel_on = pix_on_q;
  assign text_rgb      = rgb_q;

endmodule

// File: doc/text_scene_ctrl.md
# text_scene_ctrl

Scene sequencer and colour resolver for the text overlay. It tracks the game's screen (title, how-to-play, play, game-over) and decodes button edges into menu navigation. It gates and colours the per-pixel text hits produced by the text layer, emitting one registered 12-bit RGB text pixel per clock. It sits between the text layer's `*_on` outputs and the VGA colour mux, and its `game_run` output enables the gameplay logic.

## Interface
Parameters:
- `BLINK_FRAMES`, 15: frames per blink half-period for the selected menu item.
- `HOWTO_FRAMES`, 600: frames before the how-to screen auto-returns to title.
- `OVER_FRAMES`, 180: frames the game-over screen is held before returning to title.

Ports (clock and reset first):
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset. Synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse per frame, at vblank start.
- `btn_select` input 1: synchronized, debounced level. Its rising edge moves the menu cursor.
- `btn_confirm` input 1: synchronized, debounced level. Its rising edge confirms.
- `game_over` input 1: one-cycle pulse from game logic.
- `start_text_on`, `howto_title_on`, `score_text_on`, `hp_text_on` input 1 each: text-layer hits.
- `instr_line1_on` … `instr_line6_on`, `instr_green_on`, `instr_red_on` input 1 each: instruction-text hits.
- `scene` output 2: 0 = TITLE, 1 = HOWTO, 2 = PLAY, 3 = OVER.
- `cursor` output 1: 0 = START, 1 = HOW TO PLAY.
- `game_run` output 1: high iff `scene` = PLAY.
- `text_pixel_on` output 1: registered. High when `text_rgb` is valid text.
- `text_rgb` output 12: registered colour, {R4, G4, B4}.

## Operation
**Edge detection**
- Edge detect uses a 1-cycle delayed copy of each button; the delay registers reset to 0.
- Only rising edges act.

**Transition requests**
- Requests are not applied immediately. An event sets `pend_valid`/`pend_scene`.
- Events that generate requests:
  - TITLE, confirm edge: request PLAY if `cursor` = 0, HOWTO if `cursor` = 1.
  - TITLE, select edge: `cursor` toggles immediately; no request.
  - HOWTO: confirm edge, or `timer` reaching `HOWTO_FRAMES`, requests TITLE.
  - PLAY: `game_over` requests OVER.
  - OVER: `timer` reaching `OVER_FRAMES` requests TITLE. Buttons are ignored.
- While `pend_valid` = 1, all new events (buttons, `game_over`, timeouts) are ignored.
- `game_over` outside PLAY is ignored.
- Select and confirm edges in the same cycle: confirm wins. It uses the pre-toggle `cursor`, and the cursor does not toggle.

**Commit**
- In a cycle with `frame_tick` and `pend_valid` = 1 set in an earlier cycle:
  - `scene` <= `pend_scene`, and `pend_valid` clears.
  - `timer` and the blink counter clear, and `blink_phase` <= 1.
  - `cursor` <= 0 when the committed scene is TITLE.
- An event coincident with `frame_tick` is pended and commits at the following `frame_tick`.

**Counters**
- `timer`: 10-bit. Increments on `frame_tick` in HOWTO and OVER, saturates at 1023, and is 0 in other scenes.
- Blink counter: counts `frame_tick`s. On reaching `BLINK_FRAMES`-1 it wraps to 0 and toggles `blink_phase`.

**Colour priority per scene (first match wins; no match gives off, 000)**
- TITLE:
  - `start_text_on`: FFF if `cursor` = 0 and `blink_phase` = 1; off if `cursor` = 0 and `blink_phase` = 0; 888 if `cursor` = 1.
  - `howto_title_on`: same rules with `cursor` roles swapped.
- HOWTO:
  - `instr_green_on`: 0F0.
  - `instr_red_on`: F00.
  - Any `instr_line*_on`: FFF.
- PLAY: `score_text_on` or `hp_text_on`: FFF.
- OVER: `score_text_on` or `hp_text_on`: F00.
- `text_pixel_on` = 1 iff the resolved colour comes from a hit. A blanked blink phase gives 0.

## Timing
- Reset values:
  - `scene` = 0 (TITLE), `cursor` = 0, `game_run` = 0.
  - `text_pixel_on` = 0, `text_rgb` = 000.
  - `pend_valid` = 0, `timer` = 0, blink counter = 0, `blink_phase` = 1.
- `rst` mid-operation overrides everything in the same edge, including pending requests.
- Colour path latency is 1 clock: `*_on` at cycle N gives `text_rgb` at N+1, using `scene`/`cursor`/`blink_phase` as registered at N.
- Scene-change latency: event at cycle E → `scene` updates on the edge of the first `frame_tick` cycle after E. `game_run` follows `scene` combinationally from the register.
- The cursor toggle is visible 1 clock after the select edge.
- Timeout compare: a request is raised in the cycle after `timer` becomes equal to the limit.

## Configuration
- `TEXT_BLINK_EN` defined: the selected menu item blinks as described.
- `TEXT_BLINK_EN` undefined:
  - The blink counter and `blink_phase` are not built.
  - The selected item is steady FF0 (yellow); the unselected item is 888.
  - All other behaviour is identical.

## Test plan
- Reset, hold `start_text_on` = 1, `BLINK_FRAMES` = 2, 8 frame_ticks → `text_rgb` alternates FFF/000 every 2 frames (with `TEXT_BLINK_EN`); `scene` = 0.
- Select edge then confirm edge mid-frame → `cursor` = 1 a clock after select; `scene` = 1 only at the next `frame_tick`; `instr_green_on` = 1 → 0F0, `instr_red_on` = 1 → F00.
- Select and confirm in the same cycle with `cursor` = 0 → `cursor` stays 0, `scene` becomes 2 at the next `frame_tick`, `game_run` = 1.
- PLAY, pulse `game_over` on a `frame_tick` cycle → no change on that tick; `scene` = 3 at the next tick; `score_text_on` → F00. With `OVER_FRAMES` = 4, TITLE follows after 4 more ticks plus one commit tick; confirm edges during OVER are ignored.
- HOWTO with `HOWTO_FRAMES` = 3, no buttons → returns to TITLE with `cursor` = 0. Confirm pressed while a request is pending changes nothing.
- Assert `rst` for 1 cycle while a request is pending in HOWTO → next cycle `scene` = 0, `pend_valid` = 0, `text_rgb` = 000; the following `frame_tick` causes no scene change.
